sum_accumulator: RTL and testbench

Downstream consumer of the 8-bit operand adder stage. It takes the stream of 9-bit registered sums, adds a programmable number of consecutive valid sums into a saturating accumulator, and presents each completed frame total on a valid/ready output port. It sits between the adder pipeline and the block's result sink. It is the only place in the datapath where backpressure is applied.

---
 rtl/shift_pkg.sv | 16 +
 rtl/sum_accumulator_sat_add.sv | 18 +
 rtl/sum_accumulator.sv | 102 ++++++++++
 tb/tb_sum_accumulator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, limits and state encoding for the accumulate stage
package shift_pkg;

  localparam int IN_W  = 9;
  localparam int ACC_W = 12;
  localparam int LEN_W = 4;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// rtl/sum_accumulator_sat_add.sv - combinational saturating add of an incoming sum onto an accumulator
module sat_add
  import shift_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o
);

  logic [ACC_W:0] full_sum;

  // One extra bit catches any carry out of the accumulator width
  assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - IN_W){1'b0}}, add_i};
  assign sat_o    = full_sum[ACC_W];
  assign sum_o    = sat_o ? ACC_MAX : full_sum[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frames consecutive valid sums into saturating totals behind a valid/ready port
module sum_accumulator
  import shift_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic [LEN_W-1:0] frame_len,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             drop
);

  localparam logic [LEN_W:0] LEN_FULL = (LEN_W + 1)'(2 ** LEN_W);
  localparam logic [LEN_W:0] LEN_ONE  = (LEN_W + 1)'(1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [LEN_W:0]   len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             start_frame;
  logic [LEN_W:0]   len_new;
  logic [ACC_W-1:0] sat_sum;
  logic             sat_flag;

  sat_add u_sat_add (
    .acc_i (acc_q),
    .add_i (sum_in),
    .sum_o (sat_sum),
    .sat_o (sat_flag)
  );

  // Backpressure exists only while a finished frame waits on the sink
  assign sum_ready = (state_q == HOLD) ? out_ready : 1'b1;
  assign accept    = sum_valid & sum_ready;
  assign drop      = sum_valid & ~sum_ready;
  assign acc_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign len_new   = (frame_len == '0) ? LEN_FULL : {1'b0, frame_len};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    start_frame = 1'b0;

    case (state_q)
      IDLE: start_frame = accept;
      ACCUM: begin
        if (accept) begin
          acc_d = sat_sum;
          ovf_d = ovf_q | sat_flag;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          start_frame = accept;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame launched from HOLD overrides the return to IDLE, so there is no bubble
    if (start_frame) begin
      acc_d   = {{(ACC_W - IN_W){1'b0}}, sum_in};
      cnt_d   = LEN_ONE;
      len_d   = len_new;
      ovf_d   = 1'b0;
      state_d = (len_new == LEN_ONE) ? HOLD : ACCUM;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator with directed and randomized frames
module tb_sum_accumulator;
  import shift_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  sum_in;
  logic             sum_valid;
  logic             sum_ready;
  logic [LEN_W-1:0] frame_len;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             out_ready;
  logic             overflow;
  logic             drop;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sum_accumulator dut (
    .clock     (clock),
    .reset     (reset),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .frame_len (frame_len),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .drop      (drop)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int s, input int fl, input logic ordy);
    sum_valid = v;
    sum_in    = IN_W'(s);
    frame_len = LEN_W'(fl);
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b1);
    tick;
    tick;
    if (acc_out !== '0) $display("FAIL reset_acc_out got %0d want 0", acc_out); else pass_cnt++;
    total_cnt++;
    if (acc_valid !== 1'b0) $display("FAIL reset_acc_valid got %b want 0", acc_valid); else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++;
    if (drop !== 1'b0) $display("FAIL reset_drop got %b want 0", drop); else pass_cnt++;
    total_cnt++;
    if (sum_ready !== 1'b1) $display("FAIL reset_sum_ready got %b want 1", sum_ready); else pass_cnt++;
    total_cnt++;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 10 * (i + 1), 4, 1'b1);
      if (i == 3) begin
        if (acc_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", acc_valid); else pass_cnt++;
        total_cnt++;
      end
      tick;
    end
    drive(1'b0, 0, 4, 1'b1);
    if (acc_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", acc_valid); else pass_cnt++;
    total_cnt++;
    if (acc_out !== 12'd100) $display("FAIL basic_acc_out got %0d want 100", acc_out); else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL basic_overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++;
    tick;
    if (acc_valid !== 1'b0) $display("FAIL basic_after_handshake got %b want 0", acc_valid); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 510, 0, 1'b1);
      tick;
    end
    drive(1'b0, 0, 0, 1'b1);
    if (acc_valid !== 1'b1 || acc_out !== 12'd4095 || overflow !== 1'b1)
      $display("FAIL sat_frame got valid=%b acc=%0d ovf=%b want valid=1 acc=4095 ovf=1",
               acc_valid, acc_out, overflow);
    else pass_cnt++;
    total_cnt++;
    tick;
    drive(1'b1, 1, 2, 1'b1);
    tick;
    drive(1'b1, 2, 2, 1'b1);
    tick;
    drive(1'b0, 0, 2, 1'b1);
    if (acc_valid !== 1'b1 || acc_out !== 12'd3 || overflow !== 1'b0)
      $display("FAIL sat_next_frame got valid=%b acc=%0d ovf=%b want valid=1 acc=3 ovf=0",
               acc_valid, acc_out, overflow);
    else pass_cnt++;
    total_cnt++;
    tick;
  endtask

  task automatic test_backpressure;
    int drops;
    drops = 0;
    drive(1'b1, 5, 2, 1'b1);
    tick;
    drive(1'b1, 6, 2, 1'b1);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 99, 2, 1'b0);
      if (drop === 1'b1) drops++;
      if (sum_ready !== 1'b0 || acc_valid !== 1'b1 || acc_out !== 12'd11)
        $display("FAIL bp_hold got ready=%b valid=%b acc=%0d want ready=0 valid=1 acc=11",
                 sum_ready, acc_valid, acc_out);
      else pass_cnt++;
      total_cnt++;
      tick;
    end
    if (drops !== 3) $display("FAIL bp_drop_count got %0d want 3", drops); else pass_cnt++;
    total_cnt++;
    drive(1'b1, 7, 2, 1'b1);
    if (drop !== 1'b0 || sum_ready !== 1'b1)
      $display("FAIL bp_release got drop=%b ready=%b want drop=0 ready=1", drop, sum_ready);
    else pass_cnt++;
    total_cnt++;
    tick;
    if (acc_valid !== 1'b0) $display("FAIL bp_new_frame_valid got %b want 0", acc_valid); else pass_cnt++;
    total_cnt++;
    drive(1'b1, 1, 2, 1'b1);
    tick;
    drive(1'b0, 0, 2, 1'b1);
    if (acc_valid !== 1'b1 || acc_out !== 12'd8)
      $display("FAIL bp_new_frame_total got valid=%b acc=%0d want valid=1 acc=8", acc_valid, acc_out);
    else pass_cnt++;
    total_cnt++;
    tick;
  endtask

  task automatic test_single;
    int vals[3];
    vals = '{9, 8, 7};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1, 1'b1);
      tick;
      if (acc_valid !== 1'b1 || acc_out !== ACC_W'(vals[i]))
        $display("FAIL single_%0d got valid=%b acc=%0d want valid=1 acc=%0d",
                 i, acc_valid, acc_out, vals[i]);
      else pass_cnt++;
      total_cnt++;
    end
    drive(1'b0, 0, 1, 1'b1);
    tick;
    if (acc_valid !== 1'b0) $display("FAIL single_drain got %b want 0", acc_valid); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 100, 8, 1'b1);
      tick;
    end
    drive(1'b0, 0, 8, 1'b1);
    reset = 1'b1;
    #1;
    if (acc_out !== '0 || acc_valid !== 1'b0 || overflow !== 1'b0 || drop !== 1'b0 || sum_ready !== 1'b1)
      $display("FAIL midreset_outputs got acc=%0d valid=%b ovf=%b drop=%b ready=%b want 0 0 0 0 1",
               acc_out, acc_valid, overflow, drop, sum_ready);
    else pass_cnt++;
    total_cnt++;
    tick;
    reset = 1'b0;
    drive(1'b1, 1, 2, 1'b1);
    tick;
    drive(1'b1, 1, 2, 1'b1);
    tick;
    drive(1'b0, 0, 2, 1'b1);
    if (acc_valid !== 1'b1 || acc_out !== 12'd2)
      $display("FAIL midreset_next got valid=%b acc=%0d want valid=1 acc=2", acc_valid, acc_out);
    else pass_cnt++;
    total_cnt++;
    tick;
  endtask

  task automatic test_gapped;
    drive(1'b1, 3, 3, 1'b1);
    tick;
    drive(1'b0, 0, 3, 1'b1);
    tick;
    tick;
    drive(1'b1, 4, 5, 1'b1);
    tick;
    drive(1'b0, 0, 5, 1'b1);
    if (acc_valid !== 1'b0) $display("FAIL gapped_early got %b want 0", acc_valid); else pass_cnt++;
    total_cnt++;
    tick;
    drive(1'b1, 5, 5, 1'b1);
    tick;
    drive(1'b0, 0, 5, 1'b1);
    if (acc_valid !== 1'b1 || acc_out !== 12'd12)
      $display("FAIL gapped_total got valid=%b acc=%0d want valid=1 acc=12", acc_valid, acc_out);
    else pass_cnt++;
    total_cnt++;
    tick;
  endtask

  // Reference: a frame is a list of accepted samples whose total is clipped once at the end
  task automatic test_random;
    bit pend, in_frame, v, ordy, exp_ready;
    int exp_total, cur_sum, cur_cnt, cur_len, s, fl;
    bit exp_ovf;
    pend = 0;
    in_frame = 0;
    exp_total = 0;
    exp_ovf = 0;
    cur_sum = 0;
    cur_cnt = 0;
    cur_len = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      s    = ($urandom_range(0, 3) == 0) ? $urandom_range(480, 511) : $urandom_range(0, 511);
      fl   = $urandom_range(0, 15);
      ordy = ($urandom_range(0, 9) < 7);
      drive(v, s, fl, ordy);
      exp_ready = !pend || ordy;
      if (sum_ready !== exp_ready || drop !== (v && !exp_ready) || acc_valid !== pend)
        $display("FAIL rand_ctrl cyc %0d got ready=%b drop=%b valid=%b want %b %b %b",
                 cyc, sum_ready, drop, acc_valid, exp_ready, v && !exp_ready, pend);
      else pass_cnt++;
      total_cnt++;
      if (pend) begin
        if (acc_out !== ACC_W'(exp_total) || overflow !== exp_ovf)
          $display("FAIL rand_frame cyc %0d got acc=%0d ovf=%b want acc=%0d ovf=%b",
                   cyc, acc_out, overflow, exp_total, exp_ovf);
        else pass_cnt++;
        total_cnt++;
      end
      if (pend && ordy) pend = 0;
      if (v && exp_ready) begin
        if (!in_frame) begin
          in_frame = 1;
          cur_len  = (fl == 0) ? 16 : fl;
          cur_sum  = s;
          cur_cnt  = 1;
        end else begin
          cur_sum += s;
          cur_cnt++;
        end
        if (cur_cnt == cur_len) begin
          in_frame  = 0;
          pend      = 1;
          exp_ovf   = (cur_sum > int'(ACC_MAX));
          exp_total = exp_ovf ? int'(ACC_MAX) : cur_sum;
        end
      end
      tick;
    end
    drive(1'b0, 0, 0, 1'b1);
    tick;
  endtask

  initial begin
    reset     = 1'b1;
    sum_valid = 1'b0;
    sum_in    = '0;
    frame_len = '0;
    out_ready = 1'b1;
    test_reset;
    test_basic;
    test_saturation;
    test_backpressure;
    test_single;
    test_reset_mid;
    test_gapped;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
